// File: rtl/buffer_fill_ctrl.sv
// Write-side fill controller for the per-row activation FIFOs of the systolic array.
// Steers one valid/ready word stream row-major into ROWS buffers, COL_LEN words per row, for a programmed tile count.
module buffer_fill_ctrl #(
    parameter int ROWS    = 4,
    parameter int DWIDTH  = 16,
    parameter int COL_LEN = 8,
    parameter int TILES_W = 8
) (
    input  logic               wr_clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [TILES_W-1:0] num_tiles,
    input  logic               s_valid,
    input  logic [DWIDTH-1:0]  s_data,
    output logic               s_ready,
    input  logic [ROWS-1:0]    buf_full,
    output logic [ROWS-1:0]    buf_wr_en,
    output logic [DWIDTH-1:0]  buf_din,
    output logic               busy,
    output logic               done,
    output logic [TILES_W-1:0] tile_cnt
);

    localparam int WCW = (COL_LEN > 1) ? $clog2(COL_LEN) : 1;
    localparam int RSW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [WCW-1:0] WORD_LAST = WCW'(COL_LEN - 1);
    localparam logic [RSW-1:0] ROW_LAST  = RSW'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RSW-1:0]     r_row_sel;
    logic [WCW-1:0]     r_word_cnt;
    logic [TILES_W-1:0] r_tile_cnt;
    logic [TILES_W-1:0] r_tiles_lat;

    logic               w_sel_full;
    logic               w_xfer;
    logic               w_row_end;
    logic               w_tile_end;
    logic [TILES_W-1:0] w_tile_inc;

    assign w_sel_full = buf_full[r_row_sel];
    assign w_row_end  = (r_word_cnt == WORD_LAST);
    assign w_tile_end = w_row_end && (r_row_sel == ROW_LAST);
    // tile_cnt only ever climbs to tiles_lat, so the increment cannot wrap.
    assign w_tile_inc = r_tile_cnt + TILES_W'(1);

    assign buf_din  = s_data;
    assign tile_cnt = r_tile_cnt;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        w_xfer      = 1'b0;
        buf_wr_en   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_state_nxt = (num_tiles != '0) ? ST_FILL : ST_DONE;
            end
            ST_FILL: begin
                busy    = 1'b1;
                // Gated by rstn so a reset cycle never issues a write.
                s_ready = rstn & ~w_sel_full;
                w_xfer  = s_ready & s_valid;
                if (w_xfer) begin
                    buf_wr_en[r_row_sel] = 1'b1;
                    if (w_tile_end && (w_tile_inc == r_tiles_lat))
                        w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wr_clk) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge wr_clk) begin
        if (!rstn) begin
            r_row_sel   <= '0;
            r_word_cnt  <= '0;
            r_tile_cnt  <= '0;
            r_tiles_lat <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_tiles_lat <= num_tiles;
            r_tile_cnt  <= '0;
            r_row_sel   <= '0;
            r_word_cnt  <= '0;
        end else if (w_xfer) begin
            if (w_row_end) begin
                r_word_cnt <= '0;
                if (r_row_sel == ROW_LAST) begin
                    r_row_sel  <= '0;
                    r_tile_cnt <= w_tile_inc;
                end else begin
                    r_row_sel <= r_row_sel + RSW'(1);
                end
            end else begin
                r_word_cnt <= r_word_cnt + WCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// Directed self-checking bench for buffer_fill_ctrl with default parameters (4 rows x 8 words).
// Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_buffer_fill_ctrl;

    logic        wr_clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  num_tiles;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [3:0]  buf_full;
    logic [3:0]  buf_wr_en;
    logic [15:0] buf_din;
    logic        busy;
    logic        done;
    logic [7:0]  tile_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int n_done   = 0;
    int wr_base;
    int done_base;

    buffer_fill_ctrl #(.ROWS(4), .DWIDTH(16), .COL_LEN(8), .TILES_W(8)) dut (
        .wr_clk    (wr_clk),
        .rstn      (rstn),
        .start     (start),
        .num_tiles (num_tiles),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .buf_full  (buf_full),
        .buf_wr_en (buf_wr_en),
        .buf_din   (buf_din),
        .busy      (busy),
        .done      (done),
        .tile_cnt  (tile_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) begin
        if (buf_wr_en != 4'b0000) n_wr++;
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic start_job(input logic [7:0] n);
        @(negedge wr_clk);
        start = 1'b1; num_tiles = n; s_valid = 1'b0; buf_full = 4'b0000;
        @(negedge wr_clk);
        start = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d, input int row, input int tiles, input logic [3:0] full);
        logic [3:0] exp_en;
        exp_en = 4'b0001 << row;
        @(negedge wr_clk);
        start = 1'b0; s_valid = 1'b1; s_data = d; buf_full = full;
        #1;
        check("push_ready", s_ready, 1);
        check("push_wr_en", buf_wr_en, exp_en);
        check("push_din", buf_din, d);
        check("push_tile_cnt", tile_cnt, tiles);
    endtask

    task automatic idle_cycle();
        @(negedge wr_clk);
        start = 1'b0; s_valid = 1'b0; buf_full = 4'b0000;
        #1;
        check("gap_wr_en", buf_wr_en, 0);
        check("gap_ready", s_ready, 1);
    endtask

    task automatic finish_check(input int tiles);
        @(negedge wr_clk);
        s_valid = 1'b0; buf_full = 4'b0000;
        #1;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_ready", s_ready, 0);
        check("done_wr_en", buf_wr_en, 0);
        check("done_tile_cnt", tile_cnt, tiles);
        @(negedge wr_clk);
        #1;
        check("after_done", done, 0);
        check("after_busy", busy, 0);
        check("after_tile_cnt", tile_cnt, tiles);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; num_tiles = '0; s_valid = 1'b0; s_data = '0; buf_full = '0;
        repeat (3) @(negedge wr_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", s_ready, 0);
        check("rst_wr_en", buf_wr_en, 0);
        check("rst_tile_cnt", tile_cnt, 0);
        @(negedge wr_clk);
        rstn = 1'b1;

        // Basic single-tile fill.
        wr_base = n_wr; done_base = n_done;
        start_job(8'd1);
        for (int i = 0; i < 32; i++) push_word(16'(i), i / 8, 0, 4'b0000);
        finish_check(1);
        check("basic_writes", n_wr - wr_base, 32);
        check("basic_dones", n_done - done_base, 1);

        // Back-pressure on the selected row; full on an unselected row is ignored.
        wr_base = n_wr;
        start_job(8'd1);
        for (int i = 0; i < 10; i++) push_word(16'(16'h100 + i), i / 8, 0, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            @(negedge wr_clk);
            s_valid = 1'b1; s_data = 16'hdead; buf_full = 4'b0010;
            #1;
            check("bp_ready", s_ready, 0);
            check("bp_wr_en", buf_wr_en, 0);
        end
        for (int i = 10; i < 16; i++)
            push_word(16'(16'h100 + i), 1, 0, (i % 2 == 0) ? 4'b1000 : 4'b0000);
        for (int i = 16; i < 32; i++) push_word(16'(16'h100 + i), i / 8, 0, 4'b0000);
        finish_check(1);
        check("bp_writes", n_wr - wr_base, 32);

        // Three tiles with random upstream gaps.
        wr_base = n_wr; done_base = n_done;
        start_job(8'd3);
        for (int i = 0; i < 96; i++) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
            push_word(16'(16'h2000 + i), (i / 8) % 4, i / 32, 4'b0000);
        end
        finish_check(3);
        check("multi_writes", n_wr - wr_base, 96);
        check("multi_dones", n_done - done_base, 1);

        // Empty job: straight to DONE with no writes.
        wr_base = n_wr; done_base = n_done;
        start_job(8'd0);
        #1;
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        check("zero_ready", s_ready, 0);
        @(negedge wr_clk);
        #1;
        check("zero_after_done", done, 0);
        check("zero_after_busy", busy, 0);
        check("zero_writes", n_wr - wr_base, 0);
        check("zero_dones", n_done - done_base, 1);

        // Reset after word 13 abandons the job.
        start_job(8'd1);
        for (int i = 0; i < 14; i++) push_word(16'(16'h300 + i), i / 8, 0, 4'b0000);
        @(negedge wr_clk);
        rstn = 1'b0; s_valid = 1'b1; s_data = 16'h030e;
        wr_base = n_wr;
        #1;
        check("rstjob_wr_en", buf_wr_en, 0);
        check("rstjob_ready", s_ready, 0);
        @(negedge wr_clk);
        rstn = 1'b1; s_valid = 1'b0;
        #1;
        check("rstjob_writes", n_wr - wr_base, 0);
        check("rstjob_busy", busy, 0);
        check("rstjob_done", done, 0);
        check("rstjob_tile_cnt", tile_cnt, 0);
        start_job(8'd1);
        for (int i = 0; i < 32; i++) push_word(16'(16'h400 + i), i / 8, 0, 4'b0000);
        finish_check(1);

        // start during FILL and during DONE is ignored.
        wr_base = n_wr; done_base = n_done;
        start_job(8'd1);
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                @(negedge wr_clk);
                start = 1'b1; num_tiles = 8'd5; s_valid = 1'b1; s_data = 16'h050a; buf_full = 4'b0000;
                #1;
                check("ign_wr_en", buf_wr_en, 4'b0010);
            end else begin
                push_word(16'(16'h500 + i), i / 8, 0, 4'b0000);
            end
        end
        @(negedge wr_clk);
        s_valid = 1'b0; start = 1'b1; num_tiles = 8'd2;
        #1;
        check("ign_done", done, 1);
        check("ign_tile_cnt", tile_cnt, 1);
        @(negedge wr_clk);
        start = 1'b0;
        #1;
        check("ign_idle_busy", busy, 0);
        @(negedge wr_clk);
        #1;
        check("ign_still_idle", busy, 0);
        check("ign_final_tile_cnt", tile_cnt, 1);
        check("ign_writes", n_wr - wr_base, 32);
        check("ign_dones", n_done - done_base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
